// File: rtl/xt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xt_pkg : shared types for the x_t tile fetch path                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package xt_pkg;

  localparam int XT_ADDR_W    = 6;
  localparam int XT_DATA_W    = 16;
  localparam int XT_TILE_SIZE = 4;
  localparam int XT_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xt_state_e;

  typedef logic signed [XT_DATA_W-1:0] xt_elem_t;
  typedef xt_elem_t [XT_TILE_SIZE-1:0] xt_vec_t;

  typedef struct packed {
    xt_vec_t              vec;
    logic [XT_ADDR_W-1:0] idx;
    logic                 last;
  } xt_tile_t;

endpackage
`default_nettype wire

// File: rtl/xt_fetch_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xt_fetch_ctrl_if : ROM read bus plus tile valid/ready stream     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface xt_fetch_ctrl_if;
  import xt_pkg::*;

  logic                 xt_en;
  logic [XT_ADDR_W-1:0] xt_addr;
  xt_vec_t              xt_din_vec;
  xt_vec_t              tile_vec;
  logic                 tile_valid;
  logic                 tile_ready;
  logic [XT_ADDR_W-1:0] tile_idx;
  logic                 tile_last;

  modport master (
    output xt_en, xt_addr, tile_vec, tile_valid, tile_idx, tile_last,
    input  xt_din_vec, tile_ready
  );

  modport slave (
    input  xt_en, xt_addr, tile_vec, tile_valid, tile_idx, tile_last,
    output xt_din_vec, tile_ready
  );
endinterface
`default_nettype wire

// File: rtl/xt_tile_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xt_tile_fifo : small synchronous FIFO of tagged tiles with flush |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module xt_tile_fifo
  import xt_pkg::*;
#(
  parameter  int DEPTH = XT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  xt_tile_t         push_tile,
  input  logic             pop,
  output xt_tile_t         head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  xt_tile_t         mem_q [DEPTH];
  xt_tile_t         mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign pop_ok = pop && !empty;
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_tile;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop_ok) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_ok && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The fetch controller's read credit keeps pushes away from a full FIFO.
  a_no_push_on_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !flush));

endmodule
`default_nettype wire

// File: rtl/xt_fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xt_fetch_ctrl : sequences x_t ROM tile reads into a valid/ready  |
// | stream, absorbing the one-cycle ROM read latency. Rev 1.0        |
// +------------------------------------------------------------------+
module xt_fetch_ctrl
  import xt_pkg::*;
#(
  parameter int ADDR_W     = XT_ADDR_W,
  parameter int DATA_W     = XT_DATA_W,
  parameter int TILE_SIZE  = XT_TILE_SIZE,
  parameter int FIFO_DEPTH = XT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W:0]   cfg_num_tiles,
  output logic              busy,
  output logic              done,
  xt_fetch_ctrl_if.master   bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]  MAX_TILES = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  TILE_ONE  = (ADDR_W + 1)'(1);
  localparam logic [CNT_W:0]   CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

  xt_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xt_en_q, xt_en_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   issued_cnt_q, issued_cnt_d;
  logic [ADDR_W:0]   accepted_cnt_q, accepted_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              rd_last_q, rd_last_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic [ADDR_W:0]   num_clamped;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [CNT_W:0]    outstanding;
  logic              pop;
  logic              push;
  logic              issue;
  logic [ADDR_W-1:0] issue_addr;
  logic [TILE_SIZE*DATA_W-1:0] din_flat;
  xt_tile_t          push_tile;
  xt_tile_t          head;

  xt_tile_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_tile (push_tile),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Credit counts tiles queued plus the read in flight, less the tile leaving
  // this cycle, so a depth-2 buffer still sustains one tile per cycle.
  always_comb begin
    num_clamped = (cfg_num_tiles > MAX_TILES) ? MAX_TILES : cfg_num_tiles;
    pop         = !fifo_empty && bus.tile_ready;
    outstanding = {1'b0, fifo_count} + (CNT_W + 1)'(rd_pend_q) - (CNT_W + 1)'(pop);
    issue       = (state_q == RUN) && (outstanding < CREDITS) && !abort;
    issue_addr  = base_q + issued_cnt_q[ADDR_W-1:0];
    push        = rd_pend_q && !abort;
    din_flat    = bus.xt_din_vec;
    push_tile   = '{vec: xt_vec_t'(din_flat), idx: rd_idx_q, last: rd_last_q};
  end

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    xt_en_d        = xt_en_q;
    base_d         = base_q;
    num_d          = num_q;
    issued_cnt_d   = issued_cnt_q;
    accepted_cnt_d = accepted_cnt_q;
    rd_pend_d      = issue;
    rd_idx_d       = rd_idx_q;
    rd_last_d      = rd_last_q;
    last_addr_d    = last_addr_q;

    if (issue) begin
      issued_cnt_d = issued_cnt_q + TILE_ONE;
      rd_idx_d     = issued_cnt_q[ADDR_W-1:0];
      rd_last_d    = (issued_cnt_q + TILE_ONE == num_q);
      last_addr_d  = issue_addr;
    end
    if (pop) begin
      accepted_cnt_d = accepted_cnt_q + TILE_ONE;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d         = cfg_base_addr;
          num_d          = num_clamped;
          issued_cnt_d   = '0;
          accepted_cnt_d = '0;
          busy_d         = 1'b1;
          if (num_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            xt_en_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue && (issued_cnt_q + TILE_ONE == num_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (accepted_cnt_q + TILE_ONE == num_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
          xt_en_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        xt_en_d = 1'b0;
      end
    endcase

    if (abort) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      xt_en_d   = 1'b0;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      xt_en_q        <= 1'b0;
      base_q         <= '0;
      num_q          <= '0;
      issued_cnt_q   <= '0;
      accepted_cnt_q <= '0;
      rd_pend_q      <= 1'b0;
      rd_idx_q       <= '0;
      rd_last_q      <= 1'b0;
      last_addr_q    <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      xt_en_q        <= xt_en_d;
      base_q         <= base_d;
      num_q          <= num_d;
      issued_cnt_q   <= issued_cnt_d;
      accepted_cnt_q <= accepted_cnt_d;
      rd_pend_q      <= rd_pend_d;
      rd_idx_q       <= rd_idx_d;
      rd_last_q      <= rd_last_d;
      last_addr_q    <= last_addr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.xt_en      = xt_en_q;
  // Between issues the address holds; the ROM simply re-reads it.
  assign bus.xt_addr    = issue ? issue_addr : last_addr_q;
  assign bus.tile_valid = !fifo_empty;
  assign bus.tile_vec   = fifo_empty ? '0 : head.vec;
  assign bus.tile_idx   = fifo_empty ? '0 : head.idx;
  assign bus.tile_last  = !fifo_empty && head.last;

endmodule
`default_nettype wire

// File: tb/tb_xt_fetch_ctrl.sv
`default_nettype none
// Bench for xt_fetch_ctrl: ROM model plus an expected-tile queue built from
// base/count arithmetic, checked with immediate assertions.
module tb_xt_fetch_ctrl;
  import xt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [5:0] cfg_base;
  logic [6:0] cfg_num;
  logic       busy;
  logic       done;

  xt_fetch_ctrl_if bus ();

  xt_vec_t rom [64];
  int errors = 0;
  int checks = 0;

  typedef struct {
    xt_vec_t vec;
    int      idx;
    bit      last;
  } exp_t;

  always #5 clk = ~clk;

  // ROM buffer: registered read, output zeroed while disabled
  always @(posedge clk) bus.xt_din_vec <= bus.xt_en ? rom[bus.xt_addr] : '0;

  xt_fetch_ctrl #(
    .ADDR_W     (6),
    .DATA_W     (16),
    .TILE_SIZE  (4),
    .FIFO_DEPTH (2)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .cfg_base_addr (cfg_base),
    .cfg_num_tiles (cfg_num),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 pattern 1,0,0,1, 2 random
  task automatic do_run(input string nm, input int base, input int n, input int rmode,
                        input int abort_at, input int stray_at);
    exp_t    exp_q[$];
    exp_t    e;
    int      addr_q[$];
    int      nn;
    int      first_valid = -1;
    int      done_cyc = -1;
    int      done_cnt = 0;
    bit      prev_stall = 1'b0;
    bit      fin = 1'b0;
    bit      rdy;
    xt_vec_t pv;
    int      pi;
    bit      pl;
    int      c;

    nn = (n > 64) ? 64 : n;
    for (int k = 0; k < nn; k++) begin
      e.vec  = rom[(base + k) % 64];
      e.idx  = k;
      e.last = (k == nn - 1);
      exp_q.push_back(e);
    end

    start    = 1'b1;
    cfg_base = 6'(base);
    cfg_num  = 7'(n);
    bus.tile_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({nm, " busy_after_start"}, busy, 1);

    for (c = 1; c <= 600 && !fin; c++) begin
      if (abort_at > 0 && c == abort_at + 1) begin
        check({nm, " valid_after_abort"}, bus.tile_valid, 0);
        check({nm, " busy_after_abort"}, busy, 0);
      end
      if (prev_stall) begin
        check({nm, " stall_valid_held"}, bus.tile_valid, 1);
        check({nm, " stall_vec_stable"}, bus.tile_vec, pv);
        check({nm, " stall_idx_stable"}, bus.tile_idx, pi);
        check({nm, " stall_last_stable"}, bus.tile_last, pl);
      end
      if (bus.tile_valid && first_valid < 0) first_valid = c;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (nn == 0) check({nm, " en_low_empty_run"}, bus.xt_en, 0);
      if (c == abort_at) abort = 1'b1;
      if (c == stray_at) begin
        start    = 1'b1;
        cfg_base = ~cfg_base;
        cfg_num  = 7'd3;
      end

      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.tile_ready = rdy;
      #1;
      if (bus.xt_en && (addr_q.size() == 0 || addr_q[$] != int'(bus.xt_addr)))
        addr_q.push_back(int'(bus.xt_addr));

      if (bus.tile_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check({nm, " tile_beyond_run"}, 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          check({nm, " tile_vec"}, bus.tile_vec, e.vec);
          check({nm, " tile_idx"}, bus.tile_idx, e.idx);
          check({nm, " tile_last"}, bus.tile_last, e.last);
        end
      end
      prev_stall = bus.tile_valid && !rdy && (c != abort_at);
      pv = bus.tile_vec;
      pi = int'(bus.tile_idx);
      pl = bus.tile_last;

      if (done_cyc >= 0 && c >= done_cyc + 2) fin = 1'b1;
      if (abort_at > 0 && c >= abort_at + 4) fin = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
    end

    check({nm, " finished_in_budget"}, fin, 1);
    check({nm, " busy_at_end"}, busy, 0);
    if (abort_at > 0) begin
      check({nm, " no_done_on_abort"}, done_cnt, 0);
      check({nm, " valid_low_at_end"}, bus.tile_valid, 0);
    end else begin
      check({nm, " done_once"}, done_cnt, 1);
      check({nm, " all_tiles_delivered"}, exp_q.size(), 0);
      if (rmode == 0) begin
        check({nm, " done_cycle"}, done_cyc, (nn == 0) ? 1 : 3 + nn);
        if (nn > 0) check({nm, " first_valid_cycle"}, first_valid, 3);
      end
      if (nn > 0) begin
        check({nm, " addr_count"}, addr_q.size(), nn);
        for (int k = 0; k < nn && k < addr_q.size(); k++)
          check({nm, " addr_seq"}, addr_q[k], (base + k) % 64);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    cfg_base = '0;
    cfg_num  = '0;
    bus.tile_ready = 1'b0;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        rom[i][j] = 16'(i + j);

    #12;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset xt_en", bus.xt_en, 0);
    check("reset xt_addr", bus.xt_addr, 0);
    check("reset tile_valid", bus.tile_valid, 0);
    check("reset tile_vec", bus.tile_vec, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_run("T1", 0, 4, 0, -1, -1);
    do_run("T2", 62, 4, 0, -1, -1);
    do_run("T3", 5, 8, 1, -1, -1);
    do_run("T4", 9, 0, 0, -1, -1);
    do_run("T5", 30, 16, 1, 6, -1);
    do_run("T5b", 40, 2, 0, -1, -1);

    // asynchronous reset between clock edges in the middle of a run
    start = 1'b1; cfg_base = 6'd10; cfg_num = 7'd8; bus.tile_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("T6 valid_before_reset", bus.tile_valid, 1);
    rst_n = 1'b0;
    #1;
    check("T6 rst busy", busy, 0);
    check("T6 rst done", done, 0);
    check("T6 rst xt_en", bus.xt_en, 0);
    check("T6 rst xt_addr", bus.xt_addr, 0);
    check("T6 rst tile_valid", bus.tile_valid, 0);
    check("T6 rst tile_vec", bus.tile_vec, 0);
    check("T6 rst tile_idx", bus.tile_idx, 0);
    check("T6 rst tile_last", bus.tile_last, 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run("T6b", 20, 5, 0, -1, 2);

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        rom[i][j] = 16'($urandom);
    do_run("clamp", 7, 100, 0, -1, -1);
    for (int r = 0; r < 4; r++)
      do_run("rand", int'($urandom_range(0, 63)), int'($urandom_range(1, 20)), 2, -1, -1);
    do_run("rand_abort", int'($urandom_range(0, 63)), 12, 2, 5, -1);
    do_run("after_abort", 60, 6, 1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
